// File: rtl/sd_pkg.sv
// Shared SD-over-SPI definitions: command indices, data tokens,
// block-read error codes and reader states.
package sd_pkg;

    localparam logic [6:0] CMD0  = 7'd0;
    localparam logic [6:0] CMD1  = 7'd1;
    localparam logic [6:0] CMD17 = 7'h11;

    localparam logic [7:0] TOK_START = 8'hFE;
    localparam logic [7:0] TOK_IDLE  = 8'hFF;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_R1      = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_TOKEN   = 2'd3
    } sd_err_e;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WAIT_R1,
        WAIT_TOK,
        DATA,
        CRC,
        FINISH
    } rd_state_e;

endpackage

// File: rtl/sd_rx_counter.sv
// Byte and token-poll counters for the block reader; saturating,
// with terminal-count flags for the last byte and the last poll.
module sd_rx_counter #(
    parameter int BLOCK_LEN     = 512,
    parameter int TOKEN_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic byte_clr,
    input  logic byte_inc,
    input  logic tok_clr,
    input  logic tok_inc,
    output logic byte_last,
    output logic tok_last
);

    localparam int BW = $clog2(BLOCK_LEN + 1);
    localparam int TW = $clog2(TOKEN_TIMEOUT + 1);

    localparam logic [BW-1:0] BYTE_MAX = BW'(BLOCK_LEN);
    localparam logic [BW-1:0] BYTE_END = BW'(BLOCK_LEN - 1);
    localparam logic [TW-1:0] TOK_MAX  = TW'(TOKEN_TIMEOUT);
    localparam logic [TW-1:0] TOK_END  = TW'(TOKEN_TIMEOUT - 1);

    logic [BW-1:0] byte_cnt;
    logic [TW-1:0] tok_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            tok_cnt  <= '0;
        end else begin
            if (byte_clr)
                byte_cnt <= '0;
            else if (byte_inc && byte_cnt != BYTE_MAX)
                byte_cnt <= byte_cnt + BW'(1);

            if (tok_clr)
                tok_cnt <= '0;
            else if (tok_inc && tok_cnt != TOK_MAX)
                tok_cnt <= tok_cnt + TW'(1);
        end
    end

    assign byte_last = (byte_cnt == BYTE_END);
    assign tok_last  = (tok_cnt == TOK_END);

endmodule

// File: rtl/sd_block_reader.sv
// SPI-mode SD single-block reader: CMD17, token poll, BLOCK_LEN data
// bytes with valid/ready backpressure, CRC discard, trailing idle byte.
module sd_block_reader
    import sd_pkg::*;
#(
    parameter int BLOCK_LEN     = 512,
    parameter int TOKEN_TIMEOUT = 1024,
    parameter int BYTE_ADDR     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        boot_done,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_busy,
    output logic [6:0]  cmd,
    output logic [31:0] arg,
    output logic        SDctrl_start,
    input  logic        SDctrl_available,
    input  logic        SDctrl_valid_status,
    input  logic [6:0]  SDctrl_status,
    output logic        spi_req,
    input  logic        spi_valid,
    input  logic [7:0]  spi_data,
    output logic        cs,
    output logic        data_valid,
    output logic [7:0]  data,
    input  logic        data_ready,
    output logic        done,
    output logic [1:0]  error
);

    rd_state_e   state_q, state_d;
    sd_err_e     err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic        pend_q, pend_d;
    logic        crc_q, crc_d;
    logic        cs_d, busy_d, start_d, req_d, dv_d, done_d;
    logic [6:0]  cmd_d;
    logic [31:0] arg_d;
    logic [7:0]  data_d;
    logic        byte_clr, byte_inc, tok_clr, tok_inc;
    logic        byte_last, tok_last;

    sd_rx_counter #(
        .BLOCK_LEN     (BLOCK_LEN),
        .TOKEN_TIMEOUT (TOKEN_TIMEOUT)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_clr  (byte_clr),
        .byte_inc  (byte_inc),
        .tok_clr   (tok_clr),
        .tok_inc   (tok_inc),
        .byte_last (byte_last),
        .tok_last  (tok_last)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        addr_d   = addr_q;
        pend_d   = pend_q;
        crc_d    = crc_q;
        cs_d     = cs;
        busy_d   = rd_busy;
        cmd_d    = cmd;
        arg_d    = arg;
        start_d  = 1'b0;
        req_d    = 1'b0;
        dv_d     = data_valid;
        data_d   = data;
        done_d   = 1'b0;
        byte_clr = 1'b0;
        byte_inc = 1'b0;
        tok_clr  = 1'b0;
        tok_inc  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rd_req && boot_done) begin
                    addr_d   = rd_addr;
                    cs_d     = 1'b0;
                    busy_d   = 1'b1;
                    err_d    = ERR_OK;
                    byte_clr = 1'b1;
                    tok_clr  = 1'b1;
                    state_d  = CMD;
                end
            end
            CMD: begin
                if (SDctrl_available) begin
                    cmd_d   = CMD17;
                    arg_d   = (BYTE_ADDR != 0) ? {addr_q[22:0], 9'd0} : addr_q;
                    start_d = 1'b1;
                    state_d = WAIT_R1;
                end
            end
            WAIT_R1: begin
                if (SDctrl_valid_status) begin
                    if (SDctrl_status == 7'd0) begin
                        tok_clr = 1'b1;
                        state_d = WAIT_TOK;
                    end else begin
                        err_d   = ERR_R1;
                        cs_d    = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            // Any byte that is neither start nor error token counts as a poll
            WAIT_TOK: begin
                if (!pend_q) begin
                    req_d  = 1'b1;
                    pend_d = 1'b1;
                end else if (spi_valid) begin
                    pend_d = 1'b0;
                    if (spi_data == TOK_START) begin
                        byte_clr = 1'b1;
                        state_d  = DATA;
                    end else if (spi_data[7:5] == 3'b000) begin
                        err_d   = ERR_TOKEN;
                        cs_d    = 1'b1;
                        state_d = FINISH;
                    end else begin
                        tok_inc = 1'b1;
                        if (tok_last) begin
                            err_d   = ERR_TIMEOUT;
                            cs_d    = 1'b1;
                            state_d = FINISH;
                        end
                    end
                end
            end
            DATA: begin
                if (data_valid) begin
                    if (data_ready) begin
                        dv_d     = 1'b0;
                        byte_inc = 1'b1;
                        if (byte_last) begin
                            crc_d   = 1'b0;
                            state_d = CRC;
                        end
                    end
                end else if (pend_q) begin
                    if (spi_valid) begin
                        pend_d = 1'b0;
                        dv_d   = 1'b1;
                        data_d = spi_data;
                    end
                end else if (data_ready) begin
                    req_d  = 1'b1;
                    pend_d = 1'b1;
                end
            end
            CRC: begin
                if (!pend_q) begin
                    req_d  = 1'b1;
                    pend_d = 1'b1;
                end else if (spi_valid) begin
                    pend_d = 1'b0;
                    crc_d  = 1'b1;
                    if (crc_q) begin
                        err_d   = ERR_OK;
                        cs_d    = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                if (!pend_q) begin
                    req_d  = 1'b1;
                    pend_d = 1'b1;
                end else if (spi_valid) begin
                    pend_d  = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            err_q        <= ERR_OK;
            addr_q       <= '0;
            pend_q       <= 1'b0;
            crc_q        <= 1'b0;
            cs           <= 1'b1;
            rd_busy      <= 1'b0;
            cmd          <= '0;
            arg          <= '0;
            SDctrl_start <= 1'b0;
            spi_req      <= 1'b0;
            data_valid   <= 1'b0;
            data         <= '0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            pend_q       <= pend_d;
            crc_q        <= crc_d;
            cs           <= cs_d;
            rd_busy      <= busy_d;
            cmd          <= cmd_d;
            arg          <= arg_d;
            SDctrl_start <= start_d;
            spi_req      <= req_d;
            data_valid   <= dv_d;
            data         <= data_d;
            done         <= done_d;
        end
    end

    assign error = err_q;

endmodule

// File: tb/tb_sd_block_reader.sv
// Randomized scoreboard bench for sd_block_reader with card and
// command-controller models and a transfer-level reference model.
`timescale 1ns/1ps
module tb_sd_block_reader;

    localparam int BLK = 512;
    localparam int TT  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_done = 1'b0;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        rd_busy;
    logic [6:0]  cmd;
    logic [31:0] arg;
    logic        SDctrl_start;
    logic        SDctrl_available = 1'b1;
    logic        SDctrl_valid_status = 1'b0;
    logic [6:0]  SDctrl_status = '0;
    logic        spi_req;
    logic        spi_valid = 1'b0;
    logic [7:0]  spi_data = '0;
    logic        cs;
    logic        data_valid;
    logic [7:0]  data;
    logic        data_ready = 1'b1;
    logic        done;
    logic [1:0]  error;

    always #5 clk = ~clk;

    sd_block_reader #(
        .BLOCK_LEN     (BLK),
        .TOKEN_TIMEOUT (TT),
        .BYTE_ADDR     (1)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .boot_done           (boot_done),
        .rd_req              (rd_req),
        .rd_addr             (rd_addr),
        .rd_busy             (rd_busy),
        .cmd                 (cmd),
        .arg                 (arg),
        .SDctrl_start        (SDctrl_start),
        .SDctrl_available    (SDctrl_available),
        .SDctrl_valid_status (SDctrl_valid_status),
        .SDctrl_status       (SDctrl_status),
        .spi_req             (spi_req),
        .spi_valid           (spi_valid),
        .spi_data            (spi_data),
        .cs                  (cs),
        .data_valid          (data_valid),
        .data                (data),
        .data_ready          (data_ready),
        .done                (done),
        .error               (error)
    );

    typedef struct {
        int          err;
        int          n_exch;
        logic [31:0] arg;
    } exp_t;

    logic [7:0] exp_q[$];
    exp_t       done_q[$];
    logic [7:0] card_q[$];

    int total = 0;
    int bad = 0;
    int n_exch = 0;
    int n_start = 0;
    int viol = 0;
    int acc_cnt = 0;
    int done_seen = 0;
    logic [6:0]  got_cmd = '0;
    logic [31:0] got_arg = '0;
    logic [6:0]  r1_status = '0;
    logic        rand_ready = 1'b0;
    logic [7:0]  card_byte;
    logic [7:0]  mon_byte;
    exp_t        mon_e;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Card: answers each exchange after 1..3 cycles; 0xFF once drained
    initial forever begin
        @(negedge clk);
        if (rst_n && spi_req) begin
            n_exch++;
            card_byte = 8'hFF;
            if (card_q.size() != 0) card_byte = card_q.pop_front();
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            if (rst_n) begin
                spi_valid = 1'b1;
                spi_data  = card_byte;
                @(posedge clk);
                #1;
                spi_valid = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && SDctrl_start) begin
            n_start++;
            got_cmd = cmd;
            got_arg = arg;
            repeat (2) @(posedge clk);
            #1;
            if (rst_n) begin
                SDctrl_valid_status = 1'b1;
                SDctrl_status       = r1_status;
                @(posedge clk);
                #1;
                SDctrl_valid_status = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        data_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n && spi_req && data_valid) viol++;
    end

    always @(negedge clk) begin
        if (rst_n && data_valid && data_ready) begin
            acc_cnt++;
            chk("cs_during_data", cs, 0);
            chk("data_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_byte = exp_q.pop_front();
                chk("data", data, mon_byte);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_seen++;
            chk("done_expected", done_q.size(), 1);
            if (done_q.size() != 0) begin
                mon_e = done_q.pop_front();
                chk("error", error, mon_e.err);
                chk("exchanges", n_exch, mon_e.n_exch);
                chk("cs_at_done", cs, 1);
                chk("busy_at_done", rd_busy, 0);
                chk("starts", n_start, 1);
                chk("cmd", got_cmd, 7'h11);
                chk("arg", got_arg, mon_e.arg);
                chk("data_left", exp_q.size(), 0);
                chk("req_while_valid", viol, 0);
            end
        end
    end

    function automatic logic [7:0] card_at(input int k);
        if (k < card_q.size()) return card_q[k];
        return 8'hFF;
    endfunction

    // Transfer outcome from the card script: poll for the start token,
    // then BLOCK_LEN data bytes, 2 CRC bytes and one idle byte.
    function automatic void model(input logic [6:0] r1, input logic [31:0] addr);
        exp_t       e;
        int         k;
        int         polls;
        logic [7:0] b;
        e.arg = addr << 9;
        e.err = 0;
        e.n_exch = 0;
        k = 0;
        polls = 0;
        if (r1 != 0) begin
            e.err = 1;
            e.n_exch = 1;
            done_q.push_back(e);
            return;
        end
        for (int p = 0; p < 4096; p++) begin
            b = card_at(k);
            k++;
            e.n_exch++;
            if (b == 8'hFE) break;
            if (b < 8'h20) begin
                e.err = 3;
                e.n_exch++;
                done_q.push_back(e);
                return;
            end
            polls++;
            if (polls == TT) begin
                e.err = 2;
                e.n_exch++;
                done_q.push_back(e);
                return;
            end
        end
        for (int i = 0; i < BLK; i++) begin
            exp_q.push_back(card_at(k));
            k++;
        end
        e.n_exch += BLK + 3;
        done_q.push_back(e);
    endfunction

    task automatic load_card(input int nff, input logic [7:0] tok, input bit rnd);
        card_q.delete();
        for (int i = 0; i < nff; i++) card_q.push_back(8'hFF);
        card_q.push_back(tok);
        if (tok == 8'hFE) begin
            for (int i = 0; i < BLK; i++)
                card_q.push_back(rnd ? 8'($urandom) : 8'(i));
            card_q.push_back(8'($urandom));
            card_q.push_back(8'($urandom));
        end
    endtask

    task automatic start_xfer(input logic [31:0] addr, input logic [6:0] r1);
        r1_status = r1;
        n_exch = 0;
        n_start = 0;
        viol = 0;
        acc_cnt = 0;
        model(r1, addr);
        @(posedge clk);
        #1;
        rd_addr = addr;
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic run_xfer(input logic [31:0] addr, input logic [6:0] r1, input bit extra);
        int start;
        start = done_seen;
        start_xfer(addr, r1);
        if (extra) begin
            repeat (3) @(posedge clk);
            #1;
            rd_addr = ~addr;
            rd_req = 1'b1;
            @(posedge clk);
            #1;
            rd_req = 1'b0;
        end
        for (int c = 0; c < 20000 && done_seen == start; c++) @(posedge clk);
        chk("done_count", done_seen - start, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("idle_after", rd_busy, 0);
        chk("no_restart", n_start, 1);
    endtask

    initial begin
        int snap;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", cs, 1);
        chk("rst_busy", rd_busy, 0);
        chk("rst_start", SDctrl_start, 0);
        chk("rst_req", spi_req, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_arg", arg, 0);
        chk("rst_data", data, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        rd_addr = 32'd5;
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("noboot_start", n_start, 0);
        chk("noboot_busy", rd_busy, 0);
        chk("noboot_cs", cs, 1);
        boot_done = 1'b1;

        load_card(2, 8'hFE, 1'b0);
        run_xfer(32'd3, 7'd0, 1'b1);

        card_q.delete();
        run_xfer(32'd9, 7'h04, 1'b0);

        card_q.delete();
        run_xfer(32'd7, 7'd0, 1'b0);

        load_card(1, 8'h05, 1'b0);
        run_xfer(32'd11, 7'd0, 1'b0);

        rand_ready = 1'b1;
        load_card($urandom_range(0, 10), 8'hFE, 1'b1);
        run_xfer($urandom, 7'd0, 1'b0);

        snap = done_seen;
        load_card(3, 8'hFE, 1'b1);
        start_xfer(32'd21, 7'd0);
        for (int c = 0; c < 20000 && acc_cnt < 100; c++) @(posedge clk);
        chk("reach_byte_100", acc_cnt >= 100, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs", cs, 1);
        chk("mid_rst_busy", rd_busy, 0);
        chk("mid_rst_dv", data_valid, 0);
        chk("mid_rst_req", spi_req, 0);
        chk("mid_rst_start", SDctrl_start, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", error, 0);
        chk("mid_rst_data", data, 0);
        exp_q.delete();
        done_q.delete();
        card_q.delete();
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_seen - snap, 0);

        load_card($urandom_range(0, 10), 8'hFE, 1'b1);
        run_xfer(32'd21, 7'd0, 1'b0);

        for (int t = 0; t < 3; t++) begin
            load_card($urandom_range(0, 12), 8'hFE, 1'b1);
            run_xfer($urandom, 7'd0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_block_reader.md
SD_BLOCK_READER -- requirements
Module: sd_block_reader

Interface
REQ-001 Parameter BLOCK_LEN, default 512, data bytes per block.
REQ-002 Parameter TOKEN_TIMEOUT, default 1024, max 0xFF bytes polled before the data token.
REQ-003 Parameter BYTE_ADDR, default 1; 1 = arg is rd_addr<<9 (SDSC), 0 = arg is rd_addr (SDHC).
REQ-004 Port clk, input, 1, sole clock; all logic on posedge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port boot_done, input, 1, card initialised by the boot sequencer.
REQ-007 Port rd_req, input, 1, one-cycle pulse requesting a block read.
REQ-008 Port rd_addr, input, 32, block number, sampled on an accepted rd_req.
REQ-009 Port rd_busy, output, 1, transfer in progress.
REQ-010 Port cmd, output, 7, command index to the SD command controller.
REQ-011 Port arg, output, 32, command argument to the SD command controller.
REQ-012 Port SDctrl_start, output, 1, one-cycle command launch pulse.
REQ-013 Port SDctrl_available, input, 1, command controller idle.
REQ-014 Port SDctrl_valid_status, input, 1, R1 status valid pulse.
REQ-015 Port SDctrl_status, input, 7, R1 status bits.
REQ-016 Port spi_req, output, 1, one-cycle pulse: exchange one byte, MOSI 0xFF.
REQ-017 Port spi_valid, input, 1, received byte valid pulse.
REQ-018 Port spi_data, input, 8, received byte.
REQ-019 Port cs, output, 1, card chip select, active low.
REQ-020 Port data_valid, output, 1, data byte valid.
REQ-021 Port data, output, 8, block data byte.
REQ-022 Port data_ready, input, 1, downstream accepts data.
REQ-023 Port done, output, 1, one-cycle end-of-transfer pulse.
REQ-024 Port error, output, 2, sampled with done: 0 ok, 1 R1 nonzero, 2 token timeout, 3 error token.

Function
REQ-025 States SHALL be IDLE, CMD, WAIT_R1, WAIT_TOK, DATA, CRC, FINISH.
REQ-026 IDLE: rd_req accepted only when boot_done=1; otherwise ignored, no done pulse.
REQ-027 On accept: latch rd_addr, cs<=0, rd_busy<=1, go to CMD.
REQ-028 CMD: when SDctrl_available=1, drive cmd=7'h11 and arg per REQ-003, pulse SDctrl_start for one cycle, go to WAIT_R1.
REQ-029 WAIT_R1: on SDctrl_valid_status: status 0 -> WAIT_TOK with token counter cleared; nonzero -> FINISH, error=1.
REQ-030 WAIT_TOK: issue one spi_req, then wait for spi_valid before the next; exactly one exchange outstanding at any time.
REQ-031 WAIT_TOK byte handling: 0xFF -> counter+1, repoll; 0xFE -> DATA with byte counter 0; byte with top three bits 000 -> FINISH, error=3.
REQ-032 Counter reaching TOKEN_TIMEOUT on a 0xFF byte -> FINISH, error=2.
REQ-033 DATA: spi_req issued only while data_ready=1 and data_valid=0.
REQ-034 DATA: each spi_valid registers data<=spi_data and data_valid<=1; data_valid clears the cycle after data_valid&data_ready.
REQ-035 After the BLOCK_LEN-th byte is accepted, go to CRC.
REQ-036 CRC: read and discard two bytes, not presented on data, then FINISH with error=0.
REQ-037 FINISH: one idle exchange (spi_req, await spi_valid) with cs=1; then done pulse, rd_busy<=0, IDLE.
REQ-038 rd_req while rd_busy=1 SHALL be ignored.
REQ-039 Byte counter SHALL be clog2(BLOCK_LEN+1) bits wide; token counter clog2(TOKEN_TIMEOUT+1) bits wide; no wrap.
REQ-040 spi_valid outside WAIT_TOK/DATA/CRC/FINISH and SDctrl_valid_status outside WAIT_R1 SHALL be ignored.

Reset
REQ-041 rst_n low SHALL asynchronously force IDLE, cs=1, rd_busy=0, SDctrl_start=0, spi_req=0, data_valid=0, done=0, error=0, cmd=0, arg=0, data=0, counters=0.
REQ-042 Reset mid-transfer SHALL abandon the transfer with no done pulse; the first rd_req after release starts a fresh transfer.

Structure
REQ-043 Shared package sd_pkg SHALL hold command index constants (CMD0, CMD1, CMD17), token constants (0xFE, 0xFF) and the error code enumeration.
REQ-044 Byte-level SPI exchange and command engine SHALL remain external; a sub-module sd_rx_counter (byte and timeout counters) is allowed.

Verification
REQ-045 boot_done=1, rd_req with rd_addr=3, BYTE_ADDR=1: cmd=0x11, arg=0x600, card model R1=0, 2×0xFF, 0xFE, 512 bytes 0..255 repeating, 2 CRC bytes -> 512 data bytes in order, done with error=0.
REQ-046 R1=0x04 -> no spi_req in WAIT_TOK, done with error=1, cs=1.
REQ-047 Card returns 0xFF forever, TOKEN_TIMEOUT=16 -> exactly 16 exchanges in WAIT_TOK, then done with error=2.
REQ-048 data_ready toggled randomly -> all 512 bytes received with no loss or duplication; no spi_req while data_valid=1.
REQ-049 rst_n asserted at byte 100 of DATA -> cs=1 and outputs at reset values immediately, no done; next read completes with error=0.
REQ-050 rd_req with boot_done=0, and a second rd_req while busy -> both ignored; SDctrl_start never pulsed for them.
